fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Read-side engine for the 4-entry byte FIFO.
- Drives the FIFO's rd_en and consumes its registered data_out/empty.
- Re-presents the bytes on a valid/ready byte stream for downstream consumers.
- Holds a 2-entry output skid buffer so the stream sustains 1 byte/cycle despite the FIFO's 1-cycle read latency.

Parameters:
- DATA_W, 8, byte width; must match the FIFO data width.
- BUF_DEPTH, 2, output buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  read enable; low blocks new FIFO reads, buffered bytes still drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after a pop.
- rd_en  out  1  FIFO read strobe (combinational).
- m_valid  out  1  stream byte valid.
- m_data  out  DATA_W  stream byte.
- m_ready  in  1  downstream accept.
- idle  out  1  nothing buffered, nothing in flight, FIFO empty.

Behaviour:
- Reset values: rd_en=0 (as long as state is reset), m_valid=0, m_data=0, idle=1 (fifo_empty=1).
  - Internal state cleared on reset: occupancy cnt=0, in-flight flag pend=0, buffer entries=0.
- deq = m_valid & m_ready.
- rd_en = en & ~fifo_empty & ((cnt + pend - deq) < 2).
  - Evaluated in 2-bit-plus-sign-safe arithmetic; never wraps.
  - rd_en is never asserted while fifo_empty=1, so every rd_en is a guaranteed pop.
- pend <= rd_en each cycle. When pend=1, fifo_data is captured into the buffer tail at the next edge.
- Buffer update per edge:
  - cnt_next = cnt + pend - deq.
  - Capture and dequeue in the same cycle are both honoured.
  - Ordering is strict FIFO: head is entry 0, shift on deq.
- m_valid = (cnt != 0); m_data = head entry.
  - m_data holds stable while m_valid=1 and m_ready=0.
- Latency: rd_en at cycle T, FIFO updates data_out at edge T+1, capture at edge T+2, m_valid=1 in cycle T+2. First byte appears 2 cycles after rd_en.
- Throughput: with m_ready held high and FIFO non-empty, rd_en stays high every cycle and m_valid stays high from T+2 onward.
- Backpressure:
  - With m_ready=0, at most 2 bytes are buffered or in flight; rd_en drops when cnt+pend=2.
  - No capture can ever overflow; cnt never exceeds 2.
- FIFO drains mid-stream: rd_en drops the same cycle fifo_empty=1; the already-in-flight byte is still captured.
- en deassert: takes effect the same cycle on rd_en; pend and buffer complete normally.
- idle = (cnt==0) & ~pend & fifo_empty.
- Reset mid-operation: buffer and pend are discarded immediately. A byte popped but not yet captured is lost; this is accepted and not recovered.
- Unused FIFO full flag is not an input.

Optional Feature:
- Macro: FIFO_READER_COUNT_EN.
- Defined:
  - Adds output byte_count, out, 16 bits.
  - Increments by 1 on every deq and wraps 0xFFFF to 0x0000.
  - Reset value 0.
  - Not affected by en.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst=1 then 0, fifo_empty=1 -> rd_en=0, m_valid=0, m_data=0x00, idle=1 for 10 cycles.
2. Single byte: FIFO empty=0 for one pop with data 0xA5, m_ready=1 -> rd_en high 1 cycle at T, m_valid=1 with m_data=0xA5 at T+2 only, idle=1 at T+3.
3. Streaming: FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1 -> rd_en high 4 consecutive cycles; m_data 0x11..0x44 on 4 consecutive cycles; no gaps.
4. Backpressure: same 4 bytes, m_ready=0 -> rd_en high exactly 2 cycles, cnt saturates at 2, m_data=0x11 stable. Release m_ready -> 0x11,0x22,0x33,0x44 in order, none lost or duplicated.
5. en gating plus async reset: en=0 with FIFO non-empty -> rd_en=0. Assert rst mid-stream after 0x11 delivered -> m_valid=0 within the same cycle, no further bytes until rst=0 and en=1.
6. FIFO_READER_COUNT_EN defined: deliver 5 bytes -> byte_count=5. Preset count to 0xFFFF via 65535 deqs, one more deq -> byte_count=0x0000.

Source files
------------

// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - FIFO read port and output byte stream bundle for fifo_reader
interface fifo_reader_if #(
  parameter int DATA_W = 8
);
  // FIFO read side
  logic              rd_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  // Output byte stream
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    output rd_en,
    output m_valid,
    output m_data,
    input  fifo_empty,
    input  fifo_data,
    input  m_ready
  );

  modport slave (
    input  rd_en,
    input  m_valid,
    input  m_data,
    output fifo_empty,
    output fifo_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read engine with 2-entry skid buffer; optional byte_count under FIFO_READER_COUNT_EN
module fifo_reader #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  fifo_reader_if.master      bus,
  output logic               idle
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [15:0]        byte_count
`endif
);

  localparam logic [2:0] FULL = 3'(BUF_DEPTH);

  logic [1:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              deq;
  logic              rd_en_w;
  logic [2:0]        fill;
  logic [1:0]        tail;

  assign bus.m_valid = (cnt_q != 2'd0);
  assign bus.m_data  = buf0_q;
  assign bus.rd_en   = rd_en_w;
  assign idle        = (cnt_q == 2'd0) & ~pend_q & bus.fifo_empty;

  // Read issue and buffer next-state: occupancy after this edge decides whether another pop fits
  always_comb begin
    deq     = bus.m_valid & bus.m_ready;
    fill    = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, deq};
    // No pop while reset is held: the in-flight flag is pinned clear, so the byte would vanish
    rd_en_w = ~rst & en & ~bus.fifo_empty & (fill < FULL);
    pend_d  = rd_en_w;
    cnt_d   = fill[1:0];
    tail    = cnt_q - {1'b0, deq};
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (deq) begin
      buf0_d = buf1_q;
    end
    if (pend_q) begin
      if (tail == 2'd0) begin
        buf0_d = bus.fifo_data;
      end else begin
        buf1_d = bus.fifo_data;
      end
    end
  end

  // Buffer, occupancy and in-flight state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      pend_q <= 1'b0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

`ifdef FIFO_READER_COUNT_EN
  logic [15:0] byte_count_q, byte_count_d;

  assign byte_count = byte_count_q;

  // Delivered-byte counter, wraps naturally at 16 bits
  always_comb begin
    byte_count_d = byte_count_q + {15'd0, deq};
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count_q <= 16'd0;
    end else begin
      byte_count_q <= byte_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed table-driven bench for fifo_reader
module tb_fifo_reader;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  typedef struct {
    bit         load;
    bit         en;
    bit         rdy;
    bit         e_rd;
    bit         e_v;
    logic [7:0] e_d;
    bit         e_idle;
  } vec_t;

  logic clk;
  logic rst;
  logic en;
  logic idle;
`ifdef FIFO_READER_COUNT_EN
  logic [15:0] byte_count;
`endif

  fifo_reader_if #(.DATA_W(8)) bus ();

  fifo_reader #(.DATA_W(8), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .idle       (idle)
`ifdef FIFO_READER_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         total;
  int         bad;
  logic [7:0] fq[$];
  vec_t       tbl[17];

  function automatic vec_t mk(bit ld, bit e, bit r, bit erd, bit ev, logic [7:0] ed, bit eid);
    vec_t v;
    v.load = ld; v.en = e; v.rdy = r; v.e_rd = erd; v.e_v = ev; v.e_d = ed; v.e_idle = eid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {15'd0, act}, {15'd0, exp});
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    chk(nm, {8'd0, act}, {8'd0, exp});
  endtask

  // One clock: the FIFO model pops on a sampled rd_en and updates its registered outputs after the edge
  task automatic step();
    logic rd;
    rd = bus.rd_en;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) bus.fifo_data = fq.pop_front();
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic load4();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    bus.fifo_empty = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    en  = 1'b0;
    bus.m_ready    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 8'h00;

    // streaming (rows 0-6) then backpressure and release (rows 7-16)
    tbl[0]  = mk(H, H, H, H, L, 8'h00, L);
    tbl[1]  = mk(L, H, H, H, L, 8'h00, L);
    tbl[2]  = mk(L, H, H, H, H, 8'h11, L);
    tbl[3]  = mk(L, H, H, H, H, 8'h22, L);
    tbl[4]  = mk(L, H, H, L, H, 8'h33, L);
    tbl[5]  = mk(L, H, H, L, H, 8'h44, L);
    tbl[6]  = mk(L, H, H, L, L, 8'h00, H);
    tbl[7]  = mk(H, H, L, H, L, 8'h00, L);
    tbl[8]  = mk(L, H, L, H, L, 8'h00, L);
    tbl[9]  = mk(L, H, L, L, H, 8'h11, L);
    tbl[10] = mk(L, H, L, L, H, 8'h11, L);
    tbl[11] = mk(L, H, L, L, H, 8'h11, L);
    tbl[12] = mk(L, H, H, H, H, 8'h11, L);
    tbl[13] = mk(L, H, H, H, H, 8'h22, L);
    tbl[14] = mk(L, H, H, L, H, 8'h33, L);
    tbl[15] = mk(L, H, H, L, H, 8'h44, L);
    tbl[16] = mk(L, H, H, L, L, 8'h00, H);

    // reset then idle
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("rst_rd_en", bus.rd_en, 1'b0);
      chk1("rst_m_valid", bus.m_valid, 1'b0);
      chk8("rst_m_data", bus.m_data, 8'h00);
      chk1("rst_idle", idle, 1'b1);
      step();
    end

    // single byte
    en = 1'b1;
    bus.m_ready = 1'b1;
    fq.push_back(8'hA5);
    bus.fifo_empty = 1'b0;
    #1;
    chk1("one_rd_T", bus.rd_en, 1'b1);
    chk1("one_v_T", bus.m_valid, 1'b0);
    step(); #1;
    chk1("one_rd_T1", bus.rd_en, 1'b0);
    chk1("one_v_T1", bus.m_valid, 1'b0);
    chk1("one_idle_T1", idle, 1'b0);
    step(); #1;
    chk1("one_v_T2", bus.m_valid, 1'b1);
    chk8("one_d_T2", bus.m_data, 8'hA5);
    step(); #1;
    chk1("one_v_T3", bus.m_valid, 1'b0);
    chk1("one_idle_T3", idle, 1'b1);

    // table vectors
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].load) load4();
      en = tbl[i].en;
      bus.m_ready = tbl[i].rdy;
      #1;
      chk1($sformatf("vec%0d_rd_en", i), bus.rd_en, tbl[i].e_rd);
      chk1($sformatf("vec%0d_m_valid", i), bus.m_valid, tbl[i].e_v);
      if (tbl[i].e_v) chk8($sformatf("vec%0d_m_data", i), bus.m_data, tbl[i].e_d);
      chk1($sformatf("vec%0d_idle", i), idle, tbl[i].e_idle);
      step();
    end

    // en gating, then async reset mid-stream drops the in-flight byte
    load4();
    en = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("gate_rd_en", bus.rd_en, 1'b0);
      chk1("gate_m_valid", bus.m_valid, 1'b0);
      step();
    end
    en = 1'b1;
    #1; chk1("ar_rd0", bus.rd_en, 1'b1);
    step(); #1; chk1("ar_rd1", bus.rd_en, 1'b1);
    step(); #1;
    chk1("ar_v2", bus.m_valid, 1'b1);
    chk8("ar_d2", bus.m_data, 8'h11);
    step(); #1;
    chk8("ar_d3", bus.m_data, 8'h22);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk1("ar_v_in_rst", bus.m_valid, 1'b0);
    chk8("ar_d_in_rst", bus.m_data, 8'h00);
    chk1("ar_rd_in_rst", bus.rd_en, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk1("ar_v_post", bus.m_valid, 1'b0);
    chk1("ar_rd_post", bus.rd_en, 1'b0);
    step();
    en = 1'b1;
    #1; chk1("ar_rd_resume", bus.rd_en, 1'b1);
    step(); #1;
    chk1("ar_v_gap", bus.m_valid, 1'b0);
    chk1("ar_rd_empty", bus.rd_en, 1'b0);
    step(); #1;
    chk1("ar_v_44", bus.m_valid, 1'b1);
    chk8("ar_d_44", bus.m_data, 8'h44);
    step(); #1;
    chk1("ar_idle_end", idle, 1'b1);

`ifdef FIFO_READER_COUNT_EN
    begin
      int counted;
      logic d;
      rst = 1'b1;
      #1;
      step();
      rst = 1'b0;
      #1;
      chk("cnt_reset", byte_count, 16'h0000);
      for (int i = 0; i < 5; i++) fq.push_back(8'(i + 1));
      bus.fifo_empty = 1'b0;
      en = 1'b1;
      bus.m_ready = 1'b1;
      repeat (10) step();
      #1;
      chk("cnt_five", byte_count, 16'd5);
      for (int i = 0; i < 65540; i++) fq.push_back(8'(i));
      bus.fifo_empty = 1'b0;
      counted = 5;
      for (int k = 0; k < 70000 && counted < 65535; k++) begin
        #1;
        d = bus.m_valid & bus.m_ready;
        step();
        counted += int'(d);
      end
      bus.m_ready = 1'b0;
      #1;
      chk("cnt_reached", 16'(counted), 16'hFFFF);
      chk("cnt_ffff", byte_count, 16'hFFFF);
      bus.m_ready = 1'b1;
      #1;
      chk1("cnt_wrap_v", bus.m_valid, 1'b1);
      step(); #1;
      chk("cnt_wrap", byte_count, 16'h0000);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
